// File: rtl/puzzle_pkg.sv
// Shared types and move arithmetic for the 3x3 sliding puzzle and its command player.
// apply_move is also used by the puzzle's formal properties, so keep it pure combinational.
package puzzle_pkg;

    typedef enum logic [1:0] {
        DIR_LEFT  = 2'b00,
        DIR_RIGHT = 2'b01,
        DIR_UP    = 2'b10,
        DIR_DOWN  = 2'b11
    } dir_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PLAY = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic [1:0] GRID_MAX      = 2'd2;
    localparam logic [1:0] EMPTY_ROW_RST = 2'd0;
    localparam logic [1:0] EMPTY_COL_RST = 2'd2;

    typedef struct packed {
        logic       legal;
        logic [1:0] row;
        logic [1:0] col;
    } move_res_t;

    function automatic move_res_t apply_move(input logic [1:0] row, input logic [1:0] col,
                                             input dir_t dir);
        move_res_t r;
        // NOTE: every field gets a default first, so no path leaves a value unassigned.
        r.legal = 1'b0;
        r.row   = row;
        r.col   = col;
        case (dir)
            DIR_LEFT:  if (col != 2'd0)     begin r.legal = 1'b1; r.col = col - 2'd1; end
            DIR_RIGHT: if (col <  GRID_MAX) begin r.legal = 1'b1; r.col = col + 2'd1; end
            DIR_UP:    if (row != 2'd0)     begin r.legal = 1'b1; r.row = row - 2'd1; end
            DIR_DOWN:  if (row <  GRID_MAX) begin r.legal = 1'b1; r.row = row + 2'd1; end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/move_fifo.sv
// Synchronous FIFO of direction commands; pointers carry one extra wrap bit
// so full and empty are told apart without a separate count.
module move_fifo
    import puzzle_pkg::*;
#(
    parameter int DEPTH = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  dir_t push_dir,
    input  logic pop,
    input  logic flush,
    output dir_t head,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);

    dir_t          mem_q [DEPTH];
    logic [AW:0]   wr_q;
    logic [AW:0]   rd_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else if (flush) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + (AW+1)'(1);
            if (pop)  rd_q <= rd_q + (AW+1)'(1);
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_q[AW-1:0]] <= push_dir;
    end

    assign head  = mem_q[rd_q[AW-1:0]];
    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AW-1:0] == rd_q[AW-1:0]) && (wr_q[AW] != rd_q[AW]);

endmodule

// File: rtl/puzzle_move_player.sv
// Plays a loaded move script into the puzzle, one legal move per cycle,
// dropping and counting moves that are illegal for the mirrored empty-cell position.
module puzzle_move_player
    import puzzle_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [1:0]       in_dir,
    output logic             in_ready,
    input  logic             start,
    input  logic             abort,
    input  logic             ack,
    output logic [1:0]       direction,
    output logic             dir_valid,
    output logic             busy,
    output logic             done,
    output logic [1:0]       empty_row,
    output logic [1:0]       empty_col,
    output logic [CNT_W-1:0] move_count,
    output logic [CNT_W-1:0] illegal_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q;
    dir_t             dir_q;
    logic             dir_valid_q;
    logic [1:0]       row_q;
    logic [1:0]       col_q;
    logic [CNT_W-1:0] mcnt_q;
    logic [CNT_W-1:0] icnt_q;

    logic      fifo_full;
    logic      fifo_empty;
    logic      push;
    logic      pop;
    dir_t      head;
    move_res_t move_d;

    assign in_ready = (state_q == IDLE) && !fifo_full;
    assign push     = in_valid && in_ready && !abort;
    assign pop      = (state_q == PLAY) && !fifo_empty && !abort;
    assign move_d   = apply_move(row_q, col_q, head);

    move_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dir (dir_t'(in_dir)),
        .pop      (pop),
        .flush    (abort),
        .head     (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // NOTE: all state here is sequential, so it is assigned only with non-blocking <=.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            dir_q       <= DIR_LEFT;
            dir_valid_q <= 1'b0;
            row_q       <= EMPTY_ROW_RST;
            col_q       <= EMPTY_COL_RST;
            mcnt_q      <= '0;
            icnt_q      <= '0;
        end else if (abort) begin
            state_q     <= IDLE;
            dir_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    dir_valid_q <= 1'b0;
                    if (start && !fifo_empty) begin
                        state_q <= PLAY;
                        mcnt_q  <= '0;
                        icnt_q  <= '0;
                    end
                end
                PLAY: begin
                    if (fifo_empty) begin
                        state_q     <= DONE;
                        dir_valid_q <= 1'b0;
                    end else if (move_d.legal) begin
                        dir_q       <= head;
                        dir_valid_q <= 1'b1;
                        row_q       <= move_d.row;
                        col_q       <= move_d.col;
                        if (mcnt_q != CNT_MAX) mcnt_q <= mcnt_q + CNT_W'(1);
                    end else begin
                        dir_valid_q <= 1'b0;
                        if (icnt_q != CNT_MAX) icnt_q <= icnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    dir_valid_q <= 1'b0;
                    if (ack) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign direction     = dir_q;
    assign dir_valid     = dir_valid_q;
    assign busy          = (state_q == PLAY);
    assign done          = (state_q == DONE);
    assign empty_row     = row_q;
    assign empty_col     = col_q;
    assign move_count    = mcnt_q;
    assign illegal_count = icnt_q;

endmodule

// File: tb/tb_puzzle_move_player.sv
// Directed bench for puzzle_move_player: table-driven scripts plus abort, reset,
// backpressure and counter-saturation sequences on a second, narrow-counter instance.
module tb_puzzle_move_player;
    import puzzle_pkg::*;

    localparam int DEPTH = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic [1:0] in_dir = 2'b00;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       ack = 1'b0;

    logic       in_ready, dir_valid, busy, done;
    logic [1:0] direction, empty_row, empty_col;
    logic [5:0] move_count, illegal_count;

    logic       s_in_ready, s_dir_valid, s_busy, s_done;
    logic [1:0] s_direction, s_empty_row, s_empty_col;
    logic [1:0] s_move_count, s_illegal_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    puzzle_move_player #(.DEPTH(DEPTH), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_dir(in_dir), .in_ready(in_ready),
        .start(start), .abort(abort), .ack(ack), .direction(direction),
        .dir_valid(dir_valid), .busy(busy), .done(done), .empty_row(empty_row),
        .empty_col(empty_col), .move_count(move_count), .illegal_count(illegal_count)
    );

    puzzle_move_player #(.DEPTH(DEPTH), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_dir(in_dir), .in_ready(s_in_ready),
        .start(start), .abort(abort), .ack(ack), .direction(s_direction),
        .dir_valid(s_dir_valid), .busy(s_busy), .done(s_done), .empty_row(s_empty_row),
        .empty_col(s_empty_col), .move_count(s_move_count), .illegal_count(s_illegal_count)
    );

    typedef struct {
        dir_t       d;
        logic       v;
        logic [1:0] edir;
        logic [1:0] erow;
        logic [1:0] ecol;
    } vec_t;

    vec_t tbl [7];
    int   grp_start [2] = '{0, 4};
    int   grp_len   [2] = '{4, 3};
    int   grp_mc    [2] = '{4, 1};
    int   grp_ic    [2] = '{0, 2};
    dir_t ab_moves  [10] = '{DIR_LEFT, DIR_LEFT, DIR_DOWN, DIR_RIGHT, DIR_LEFT,
                             DIR_UP, DIR_RIGHT, DIR_RIGHT, DIR_DOWN, DIR_DOWN};
    dir_t five_moves [5] = '{DIR_LEFT, DIR_LEFT, DIR_DOWN, DIR_DOWN, DIR_RIGHT};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push_move(input dir_t d);
        in_valid = 1'b1;
        in_dir   = d;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_done(input string name, output int nv);
        int w;
        w  = 0;
        nv = 0;
        while (done !== 1'b1 && w < 100) begin
            @(negedge clk);
            if (dir_valid === 1'b1) nv++;
            w++;
        end
        check({name, "_done_reached"}, done, 1);
    endtask

    initial begin
        int nv;
        int idx;

        tbl[0] = '{DIR_LEFT,  1'b1, 2'b00, 2'd0, 2'd1};
        tbl[1] = '{DIR_LEFT,  1'b1, 2'b00, 2'd0, 2'd0};
        tbl[2] = '{DIR_DOWN,  1'b1, 2'b11, 2'd1, 2'd0};
        tbl[3] = '{DIR_RIGHT, 1'b1, 2'b01, 2'd1, 2'd1};
        tbl[4] = '{DIR_RIGHT, 1'b0, 2'b00, 2'd0, 2'd2};
        tbl[5] = '{DIR_UP,    1'b0, 2'b00, 2'd0, 2'd2};
        tbl[6] = '{DIR_LEFT,  1'b1, 2'b00, 2'd0, 2'd1};

        // Reset values
        @(negedge clk);
        check("rst_direction", direction, 0);
        check("rst_dir_valid", dir_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_row", empty_row, 0);
        check("rst_col", empty_col, 2);
        check("rst_move_count", move_count, 0);
        check("rst_illegal_count", illegal_count, 0);
        check("rst_in_ready", in_ready, 1);
        rst = 1'b1;
        @(negedge clk);

        // Table-driven scripts: legal script, then illegal-move script
        for (int g = 0; g < 2; g++) begin
            do_reset();
            for (int i = 0; i < grp_len[g]; i++) push_move(tbl[grp_start[g] + i].d);
            pulse_start();
            for (int i = 0; i < grp_len[g]; i++) begin
                idx = grp_start[g] + i;
                @(negedge clk);
                check($sformatf("vec%0d_valid", idx), dir_valid, tbl[idx].v);
                check($sformatf("vec%0d_dir", idx), direction, tbl[idx].edir);
                check($sformatf("vec%0d_row", idx), empty_row, tbl[idx].erow);
                check($sformatf("vec%0d_col", idx), empty_col, tbl[idx].ecol);
            end
            @(negedge clk);
            check($sformatf("grp%0d_done", g), done, 1);
            check($sformatf("grp%0d_valid_off", g), dir_valid, 0);
            check($sformatf("grp%0d_move_count", g), move_count, grp_mc[g]);
            check($sformatf("grp%0d_illegal_count", g), illegal_count, grp_ic[g]);
        end

        // Backpressure: DEPTH+3 pushes, only DEPTH accepted
        do_reset();
        for (int i = 0; i < DEPTH + 3; i++) begin
            check($sformatf("bp_ready%0d", i), in_ready, (i < DEPTH) ? 1 : 0);
            in_valid = 1'b1;
            in_dir   = (i % 2 == 0) ? DIR_LEFT : DIR_RIGHT;
            @(negedge clk);
        end
        in_valid = 1'b0;
        pulse_start();
        in_valid = 1'b1;
        in_dir   = DIR_UP;
        check("bp_busy", busy, 1);
        check("bp_ready_in_play", in_ready, 0);
        wait_done("bp", nv);
        check("bp_valid_cycles", nv, DEPTH);
        check("bp_move_count", move_count, DEPTH);
        check("bp_illegal_count", illegal_count, 0);
        check("bp_ready_in_done", in_ready, 0);
        in_valid = 1'b0;
        pulse_ack();
        check("bp_ack_done", done, 0);
        check("bp_ack_ready", in_ready, 1);
        check("bp_ack_count_held", move_count, DEPTH);
        pulse_start();
        check("bp_fifo_drained", busy, 0);

        // Abort on the 4th play cycle
        do_reset();
        for (int i = 0; i < 10; i++) push_move(ab_moves[i]);
        pulse_start();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("ab_valid%0d", i), dir_valid, 1);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("ab_busy", busy, 0);
        check("ab_done", done, 0);
        check("ab_valid", dir_valid, 0);
        check("ab_move_count", move_count, 3);
        check("ab_illegal_count", illegal_count, 0);
        check("ab_in_ready", in_ready, 1);
        check("ab_row", empty_row, 1);
        check("ab_col", empty_col, 0);
        check("ab_dir_held", direction, 2'b11);
        abort    = 1'b1;
        in_valid = 1'b1;
        in_dir   = DIR_LEFT;
        @(negedge clk);
        abort    = 1'b0;
        in_valid = 1'b0;
        pulse_start();
        check("ab_start_empty_ignored", busy, 0);

        // Reset during PLAY
        do_reset();
        for (int i = 0; i < 5; i++) push_move(five_moves[i]);
        pulse_start();
        @(negedge clk);
        @(negedge clk);
        check("rp_valid_before", dir_valid, 1);
        #2 rst = 1'b0;
        #1;
        check("rp_row", empty_row, 0);
        check("rp_col", empty_col, 2);
        check("rp_move_count", move_count, 0);
        check("rp_illegal_count", illegal_count, 0);
        check("rp_valid", dir_valid, 0);
        check("rp_in_ready", in_ready, 1);
        check("rp_busy", busy, 0);
        @(negedge clk);
        rst = 1'b1;
        pulse_start();
        check("rp_fifo_discarded", busy, 0);

        // Saturation with CNT_W=2, then ack and restart clear
        do_reset();
        for (int i = 0; i < 5; i++) push_move(five_moves[i]);
        pulse_start();
        wait_done("sat", nv);
        check("sat_s_done", s_done, 1);
        check("sat_s_move_count", s_move_count, 3);
        check("sat_wide_move_count", move_count, 5);
        check("sat_s_row", s_empty_row, 2);
        check("sat_s_col", s_empty_col, 1);
        pulse_ack();
        check("sat_ack_done", s_done, 0);
        check("sat_ack_busy", s_busy, 0);
        check("sat_ack_count_held", s_move_count, 3);
        push_move(DIR_RIGHT);
        pulse_start();
        check("sat_restart_busy", s_busy, 1);
        check("sat_restart_clear", s_move_count, 0);
        check("sat_restart_clear_wide", move_count, 0);
        wait_done("sat2", nv);
        check("sat2_move_count", s_move_count, 1);
        check("sat2_col", s_empty_col, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
